// File: rtl/fc_pkg.sv
// Shared definitions for the flow-control FIFO producer, FIFO and flow-control FSM.
package fc_pkg;

    // Producer state encoding (2-bit binary).
    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SEND  = 2'd1,
        S_PAUSE = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    // Default widths shared with the FIFO and the flow-control FSM.
    localparam int FC_DATA_W = 8;
    localparam int FC_CNT_W  = 16;

endpackage

// File: rtl/fc_source_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones, cleared by rst.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: step only when not already at the ceiling.
    always_comb begin
        q_d = q_q;
        if (inc && (q_q != '1)) begin
            q_d = q_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fc_source.sv
// Flow-controlled producer on the write side of the flow-control FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_WAIT  | idle after reset, upstream stalled until iniciar
// S_SEND  | streaming; in_ready drops combinationally on pausa/error_full
// S_PAUSE | FIFO almost full; upstream stalled until continuar or idle
// S_ERR   | FIFO overflowed; upstream drained and dropped until idle
module fc_source
    import fc_pkg::*;
#(
    parameter int DATA_W = FC_DATA_W,
    parameter int CNT_W  = FC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iniciar,
    input  logic              pausa,
    input  logic              continuar,
    input  logic              error_full,
    input  logic              idle,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              fifo_push,
    output logic [DATA_W-1:0] fifo_data,
    output logic [CNT_W-1:0]  sent_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              err_seen,
    output logic [1:0]        state
);

    state_t            state_q, state_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_seen_q, err_seen_d;
    logic              accept;
    logic              send_inc;
    logic              drop_inc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and ready; error_full outranks pausa, which outranks continuar/idle.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (iniciar) state_d = S_SEND;
            end
            S_SEND: begin
                in_ready = !pausa && !error_full;
                if (error_full)  state_d = S_ERR;
                else if (pausa)  state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (error_full)                state_d = S_ERR;
                else if (pausa)                state_d = S_PAUSE;
                else if (continuar || idle)    state_d = S_SEND;
            end
            S_ERR: begin
                in_ready = 1'b1;
                if (idle && !error_full) state_d = S_SEND;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign send_inc = accept && (state_q == S_SEND);
    assign drop_inc = accept && (state_q == S_ERR);

    // Push/data/sticky-error next values; data only moves on a real push.
    always_comb begin
        push_d     = send_inc;
        data_d     = send_inc ? in_data : data_q;
        err_seen_d = err_seen_q || (state_d == S_ERR);
    end

    // Output registers; reset also cancels any pending push.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_q     <= 1'b0;
            data_q     <= '0;
            err_seen_q <= 1'b0;
        end else begin
            push_q     <= push_d;
            data_q     <= data_d;
            err_seen_q <= err_seen_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_sent_cnt (
        .clk (clk),
        .rst (rst),
        .inc (send_inc),
        .q   (sent_count)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drop_inc),
        .q   (drop_count)
    );

    assign fifo_push = push_q;
    assign fifo_data = data_q;
    assign err_seen  = err_seen_q;
    assign state     = state_q;

endmodule

// File: tb/tb_fc_source.sv
// Directed, table-driven bench for fc_source.
module tb_fc_source;

    logic        clk = 1'b0;
    logic        rst, iniciar, pausa, continuar, error_full, idle, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, fifo_push, err_seen;
    logic [7:0]  fifo_data;
    logic [15:0] sent_count, drop_count;
    logic [1:0]  state;

    logic        rst_s, iniciar_s, in_valid_s;
    logic [7:0]  in_data_s;
    logic        in_ready_s, fifo_push_s, err_seen_s;
    logic [7:0]  fifo_data_s;
    logic [2:0]  sent_s, drop_s;
    logic [1:0]  state_s;
    logic        zero = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fc_source #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar), .pausa(pausa),
        .continuar(continuar), .error_full(error_full), .idle(idle),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fifo_push(fifo_push), .fifo_data(fifo_data),
        .sent_count(sent_count), .drop_count(drop_count),
        .err_seen(err_seen), .state(state)
    );

    fc_source #(.DATA_W(8), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst_s), .iniciar(iniciar_s), .pausa(zero),
        .continuar(zero), .error_full(zero), .idle(zero),
        .in_data(in_data_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .fifo_push(fifo_push_s), .fifo_data(fifo_data_s),
        .sent_count(sent_s), .drop_count(drop_s),
        .err_seen(err_seen_s), .state(state_s)
    );

    typedef struct {
        logic       ini, pau, con, err, idl, val;
        logic [7:0] din;
        logic       rdy;      // in_ready during the cycle
        logic       push;     // after the edge
        logic [7:0] fdata;
        logic [1:0] st;
        int         sent, drop;
        logic       errs;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ini, pau, con, err, idl, val, input logic [7:0] din,
                       input logic rdy, push, input logic [7:0] fdata, input logic [1:0] st,
                       input int sent, drop, input logic errs);
        vec_t v;
        v.ini = ini; v.pau = pau; v.con = con; v.err = err; v.idl = idl; v.val = val;
        v.din = din; v.rdy = rdy; v.push = push; v.fdata = fdata; v.st = st;
        v.sent = sent; v.drop = drop; v.errs = errs;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; iniciar = 0; pausa = 0; continuar = 0; error_full = 0; idle = 0;
        in_valid = 0; in_data = 8'h00;
        rst_s = 1'b1; iniciar_s = 0; in_valid_s = 0; in_data_s = 8'h00;

        //       ini pau con err idl val din    rdy push fdata  st sent drop errs
        // start and 5 beats
        add(1, 0, 0, 0, 0, 0, 8'h00,  0, 0, 8'h00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h01,  1, 1, 8'h01, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h02,  1, 1, 8'h02, 1, 2, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h03,  1, 1, 8'h03, 1, 3, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h04,  1, 1, 8'h04, 1, 4, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h05,  1, 1, 8'h05, 1, 5, 0, 0);
        // pause with valid held, resume on continuar
        add(0, 0, 0, 0, 0, 1, 8'h06,  1, 1, 8'h06, 1, 6, 0, 0);
        add(0, 1, 0, 0, 0, 1, 8'h07,  0, 0, 8'h06, 2, 6, 0, 0);
        add(0, 1, 0, 0, 0, 1, 8'h08,  0, 0, 8'h06, 2, 6, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h09,  0, 0, 8'h06, 2, 6, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h0A,  0, 0, 8'h06, 2, 6, 0, 0);
        add(0, 0, 1, 0, 0, 1, 8'h0B,  0, 0, 8'h06, 1, 6, 0, 0);
        add(0, 0, 0, 0, 0, 1, 8'h0C,  1, 1, 8'h0C, 1, 7, 0, 0);
        // priority: pausa over continuar, error_full over pausa
        add(0, 1, 1, 0, 0, 0, 8'h00,  0, 0, 8'h0C, 2, 7, 0, 0);
        add(0, 1, 0, 1, 0, 1, 8'h0D,  0, 0, 8'h0C, 3, 7, 0, 1);
        // error: drop 3 beats, recover on idle
        add(0, 0, 0, 1, 0, 1, 8'h0E,  1, 0, 8'h0C, 3, 7, 1, 1);
        add(0, 0, 0, 0, 0, 1, 8'h0F,  1, 0, 8'h0C, 3, 7, 2, 1);
        add(0, 0, 0, 0, 0, 1, 8'h10,  1, 0, 8'h0C, 3, 7, 3, 1);
        add(0, 0, 0, 0, 1, 0, 8'h00,  1, 0, 8'h0C, 1, 7, 3, 1);
        add(0, 0, 0, 0, 0, 1, 8'h11,  1, 1, 8'h11, 1, 8, 3, 1);
        // error_full while streaming blocks the beat in the same cycle
        add(0, 0, 0, 1, 0, 1, 8'h12,  0, 0, 8'h11, 3, 8, 3, 1);
        add(0, 0, 0, 0, 1, 1, 8'h13,  1, 0, 8'h11, 1, 8, 4, 1);
        add(0, 0, 0, 0, 0, 0, 8'h00,  1, 0, 8'h11, 1, 8, 4, 1);
        // idle also releases a pause
        add(0, 1, 0, 0, 0, 0, 8'h00,  0, 0, 8'h11, 2, 8, 4, 1);
        add(0, 0, 0, 0, 1, 0, 8'h00,  0, 0, 8'h11, 1, 8, 4, 1);
        add(0, 0, 0, 0, 0, 1, 8'hAA,  1, 1, 8'hAA, 1, 9, 4, 1);

        step(); step();
        check("rst_state",  32'(state),      0);
        check("rst_push",   32'(fifo_push),  0);
        check("rst_data",   32'(fifo_data),  0);
        check("rst_sent",   32'(sent_count), 0);
        check("rst_drop",   32'(drop_count), 0);
        check("rst_err",    32'(err_seen),   0);
        check("rst_ready",  32'(in_ready),   0);
        check("rst_s_sent", 32'(sent_s),     0);
        rst = 1'b0; rst_s = 1'b0;

        foreach (vecs[i]) begin
            iniciar = vecs[i].ini; pausa = vecs[i].pau; continuar = vecs[i].con;
            error_full = vecs[i].err; idle = vecs[i].idl; in_valid = vecs[i].val;
            in_data = vecs[i].din;
            #1;
            check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            step();
            check($sformatf("v%0d_push", i),  32'(fifo_push),  32'(vecs[i].push));
            check($sformatf("v%0d_data", i),  32'(fifo_data),  32'(vecs[i].fdata));
            check($sformatf("v%0d_state", i), 32'(state),      32'(vecs[i].st));
            check($sformatf("v%0d_sent", i),  32'(sent_count), 32'(vecs[i].sent));
            check($sformatf("v%0d_drop", i),  32'(drop_count), 32'(vecs[i].drop));
            check($sformatf("v%0d_err", i),   32'(err_seen),   32'(vecs[i].errs));
        end

        // reset the cycle after an accepted beat cancels the pending push
        iniciar = 0; pausa = 0; continuar = 0; error_full = 0; idle = 0;
        in_valid = 1; in_data = 8'hBB;
        step();
        check("pre_rst_push", 32'(fifo_push), 1);
        check("pre_rst_data", 32'(fifo_data), 32'h BB);
        rst = 1'b1; in_data = 8'hCC;
        step();
        check("midrst_push",  32'(fifo_push),  0);
        check("midrst_data",  32'(fifo_data),  0);
        check("midrst_state", 32'(state),      0);
        check("midrst_sent",  32'(sent_count), 0);
        check("midrst_drop",  32'(drop_count), 0);
        check("midrst_err",   32'(err_seen),   0);
        rst = 1'b0; in_valid = 0;
        step();
        check("post_rst_push", 32'(fifo_push), 0);
        check("post_rst_state", 32'(state), 0);

        // saturation on a 3-bit counter
        iniciar_s = 1;
        step();
        iniciar_s = 0;
        check("sat_state", 32'(state_s), 1);
        in_valid_s = 1;
        for (int i = 1; i <= 10; i++) begin
            in_data_s = 8'(i);
            step();
            check($sformatf("sat_sent_%0d", i), 32'(sent_s), (i > 7) ? 7 : i);
            check($sformatf("sat_push_%0d", i), 32'(fifo_push_s), 1);
        end
        in_valid_s = 0;
        step();
        check("sat_hold", 32'(sent_s), 7);
        check("sat_nopush", 32'(fifo_push_s), 0);
        check("sat_last_data", 32'(fifo_data_s), 10);
        check("sat_drop", 32'(drop_s), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_source.md
# fc_source

Flow-controlled producer that writes the flow-control FIFO. It sits on the write side of the FIFO whose fill level drives the flow-control state machine. It consumes that machine's `pausa` / `continuar` / `error_full` / `idle` indications and throttles an upstream valid/ready stream accordingly. Accepted words are pushed into the FIFO one cycle later. Words arriving while the FIFO is in error are dropped and counted until the FIFO has drained.

## Interface
Parameters:
- `DATA_W`, default 8: FIFO word width.
- `CNT_W`, default 16: width of the sent and dropped counters.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `iniciar`  in  1: start request; leaves S_WAIT.
- `pausa`  in  1: FIFO almost full; stop pushing.
- `continuar`  in  1: FIFO almost empty; resume pushing.
- `error_full`  in  1: FIFO overflowed; enter error handling.
- `idle`  in  1: FIFO empty / drained.
- `in_data`  in  DATA_W: upstream word.
- `in_valid`  in  1: upstream word valid.
- `in_ready`  out  1: combinational; beat accepted when `in_valid & in_ready`.
- `fifo_push`  out  1: registered FIFO write strobe.
- `fifo_data`  out  DATA_W: registered FIFO write data.
- `sent_count`  out  CNT_W: words pushed since reset, saturating.
- `drop_count`  out  CNT_W: words dropped since reset, saturating.
- `err_seen`  out  1: sticky; set on first entry to S_ERR, cleared only by `rst`.
- `state`  out  2: current state, for debug and verification.

## Operation
States (2-bit binary): S_WAIT=0, S_SEND=1, S_PAUSE=2, S_ERR=3.

Reset values:
- State S_WAIT.
- `fifo_push`=0, `fifo_data`=0.
- `sent_count`=0, `drop_count`=0, `err_seen`=0.

S_WAIT:
- `in_ready`=0.
- `iniciar`=1 → S_SEND.

S_SEND:
- `in_ready` = `!pausa & !error_full`.
- An accepted beat registers `fifo_data`<=`in_data` and `fifo_push`<=1, and increments `sent_count`.
- Transitions, in priority order: `error_full` → S_ERR; `pausa` → S_PAUSE; otherwise stay.

S_PAUSE:
- `in_ready`=0.
- Transitions, in priority order: `error_full` → S_ERR; `pausa` → stay; `continuar` or `idle` → S_SEND.

S_ERR:
- `in_ready`=1, so upstream never stalls.
- Accepted beats are discarded: `drop_count`++, no push.
- `err_seen`<=1.
- `idle`=1 → S_SEND (FIFO drained). `iniciar` is not required to leave S_ERR.

General rules:
- `fifo_push` is 0 in every cycle that follows a non-accepting cycle; there are no duplicate pushes.
- `fifo_data` holds its last value when `fifo_push`=0.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Simultaneous `pausa` and `continuar`: `pausa` wins.
- Simultaneous `error_full` with anything: `error_full` wins.

## Timing
- Latency from accepted beat to `fifo_push`/`fifo_data` is 1 cycle.
- `pausa` or `error_full` asserted in cycle N blocks acceptance in cycle N, because `in_ready` depends combinationally on both. Producer-side overshoot is therefore 0 beats. The single word already registered from cycle N−1 still pushes in cycle N.
- State changes take effect on the edge after the triggering input is sampled.
- Counters update on the same edge as the corresponding push or drop register update.
- `rst` mid-operation:
  - Next edge forces all reset values.
  - A pending push is cancelled: `fifo_push`=0 in the cycle after reset.
  - `rst` has priority over every other input.
- `in_data` is don't-care when `in_valid`=0; nothing is registered from it.

## Structure
- Package `fc_pkg` holds:
  - The state encoding constants S_WAIT/S_SEND/S_PAUSE/S_ERR and a 2-bit state typedef.
  - Default `DATA_W`/`CNT_W` constants shared with the FIFO and the flow-control FSM.
- One sub-module, `sat_counter`, parameterised on width with `rst`, `inc` and `q`. It is instantiated twice, for `sent_count` and `drop_count`.
- Next-state logic and the output registers live in separate always blocks.

## Test plan
1. **Reset and start:** reset, then `iniciar`=1 for one cycle, then `in_valid`=1 with data 0x01..0x05 over 5 cycles. Expect `state` 0→1; `fifo_push` on cycles 1..5 after each beat with `fifo_data` 0x01..0x05; `sent_count`=5.
2. **Pause and resume:** in S_SEND, assert `pausa` at cycle 3 while `in_valid`=1. Expect `in_ready`=0 that cycle and state S_PAUSE next. Assert `continuar` 4 cycles later. Expect return to S_SEND with no lost or duplicated words: `sent_count` equals the number of accepted beats.
3. **Error, drop and recovery:** `error_full`=1 during streaming, then feed 3 beats. Expect state S_ERR, `err_seen`=1, no pushes, `drop_count`=3. Then `idle`=1: expect S_SEND, acceptance resumes, `err_seen` stays 1.
4. **Priority:** drive `pausa`=`continuar`=1 in S_SEND → expect S_PAUSE. Drive `error_full`=`pausa`=1 in S_PAUSE → expect S_ERR.
5. **Saturation:** with `CNT_W`=3, push 10 words → expect `sent_count`=7 held.
6. **Reset mid-push:** assert `rst` the cycle after an accepted beat → expect `fifo_push`=0 next cycle, all counters 0, state S_WAIT.
